// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm -- direct-mapped instruction cache, one word per line.
//
// Sits between the prefetch unit fetch port (ireq/irsp) and the memory-side
// fetch bus (mreq/mrsp). One transaction is in flight at a time. Hits answer
// one cycle after acceptance; misses refill from memory and the word is
// forwarded to the prefetch unit. flush_i invalidates every line in one cycle.
//
// Ports:
//   clk_i, resetb_i        clock, asynchronous active-low reset
//   clk_en_i               global clock enable; all state holds when low
//   ireq*                  fetch request (ready/valid, hpl, address)
//   irsp*                  fetch response (ready/valid, error, data)
//   mreq*                  memory refill request (ready/valid, hpl, address)
//   mrsp*                  memory refill response (ready/valid, error, data)
//   flush_i                invalidate all lines (FENCE.I)
//
// Optional build macro ICACHE_STATS_EN adds stat_clr_i, stat_hit_o and
// stat_miss_o: saturating counters of accepted requests by outcome.
// -----------------------------------------------------------------------------
module icache_dm #(
    parameter int C_BUS_SZX = 5,
    parameter int C_LINES_X = 4,
    parameter int C_BUS_SZ  = 2**C_BUS_SZX
) (
    input  logic                clk_i,
    input  logic                resetb_i,
    input  logic                clk_en_i,
    output logic                ireqready_o,
    input  logic                ireqvalid_i,
    input  logic [1:0]          ireqhpl_i,
    input  logic [C_BUS_SZ-1:0] ireqaddr_i,
    input  logic                irspready_i,
    output logic                irspvalid_o,
    output logic                irsprerr_o,
    output logic [C_BUS_SZ-1:0] irspdata_o,
    input  logic                mreqready_i,
    output logic                mreqvalid_o,
    output logic [1:0]          mreqhpl_o,
    output logic [C_BUS_SZ-1:0] mreqaddr_o,
    output logic                mrspready_o,
    input  logic                mrspvalid_i,
    input  logic                mrsprerr_i,
    input  logic [C_BUS_SZ-1:0] mrspdata_i,
    input  logic                flush_i
`ifdef ICACHE_STATS_EN
    ,
    input  logic                stat_clr_i,
    output logic [31:0]         stat_hit_o,
    output logic [31:0]         stat_miss_o
`endif
);

    localparam int LINES = 2**C_LINES_X;
    localparam int WA_W  = C_BUS_SZ - 2;            // word-address width
    localparam int TAG_W = C_BUS_SZ - 2 - C_LINES_X;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MREQ  = 2'd1,
        S_MWAIT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [WA_W-1:0]       addr_r;
    logic [1:0]            hpl_r;
    logic [C_BUS_SZ-1:0]   data_r;
    logic                  rerr_r;
    logic                  flushed_r;   // a flush hit the current refill
    logic [LINES-1:0]      valid_r;
    logic [TAG_W-1:0]      tag_mem_r  [LINES];
    logic [C_BUS_SZ-1:0]   data_mem_r [LINES];

    logic [C_LINES_X-1:0]  req_idx_s;
    logic [TAG_W-1:0]      req_tag_s;
    logic [C_LINES_X-1:0]  fill_idx_s;
    logic                  hit_s;
    logic                  req_acc_s;
    logic                  rsp_acc_s;
    logic                  mreq_acc_s;
    logic                  mrsp_acc_s;
    logic                  install_s;
    logic                  unused_s;

    assign unused_s = &{1'b0, ireqaddr_i[1:0]};

    // Tag lookup on the incoming address and handshake qualification
    always_comb begin
        req_idx_s  = ireqaddr_i[2 +: C_LINES_X];
        req_tag_s  = ireqaddr_i[C_BUS_SZ-1 : 2+C_LINES_X];
        fill_idx_s = addr_r[C_LINES_X-1:0];
        // A flush in the same cycle forces a miss so stale lines are never used
        hit_s      = valid_r[req_idx_s] & (tag_mem_r[req_idx_s] == req_tag_s) & ~flush_i;
        req_acc_s  = ireqready_o & ireqvalid_i;
        rsp_acc_s  = clk_en_i & (state_r == S_RESP)  & irspready_i;
        mreq_acc_s = clk_en_i & (state_r == S_MREQ)  & mreqready_i;
        mrsp_acc_s = clk_en_i & (state_r == S_MWAIT) & mrspvalid_i;
        // Error responses and refills overlapped by a flush are not installed
        install_s  = mrsp_acc_s & ~mrsprerr_i & ~flushed_r & ~flush_i;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_r <= S_IDLE;
        end else if (clk_en_i) begin
            state_r <= state_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_acc_s) begin
                    state_nxt_s = hit_s ? S_RESP : S_MREQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MREQ: begin
                if (mreq_acc_s) begin
                    state_nxt_s = S_MWAIT;
                end else begin
                    state_nxt_s = S_MREQ;
                end
            end
            S_MWAIT: begin
                if (mrsp_acc_s) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_MWAIT;
                end
            end
            S_RESP: begin
                // Back-to-back: a new request is only accepted with the response
                if (req_acc_s) begin
                    state_nxt_s = hit_s ? S_RESP : S_MREQ;
                end else if (rsp_acc_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from state and held registers
    always_comb begin
        ireqready_o = clk_en_i & ((state_r == S_IDLE) | ((state_r == S_RESP) & irspready_i));
        irspvalid_o = (state_r == S_RESP);
        mreqvalid_o = (state_r == S_MREQ);
        mrspready_o = (state_r == S_MWAIT);
        irsprerr_o  = rerr_r;
        irspdata_o  = data_r;
        mreqaddr_o  = {addr_r, 2'b00};
        mreqhpl_o   = hpl_r;
    end

    // Transaction registers: request address/hpl, response data/error
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            addr_r    <= '0;
            hpl_r     <= 2'b00;
            data_r    <= '0;
            rerr_r    <= 1'b0;
            flushed_r <= 1'b0;
        end else if (clk_en_i) begin
            if (req_acc_s) begin
                addr_r    <= ireqaddr_i[C_BUS_SZ-1:2];
                hpl_r     <= ireqhpl_i;
                flushed_r <= 1'b0;
                if (hit_s) begin
                    data_r <= data_mem_r[req_idx_s];
                    rerr_r <= 1'b0;
                end
            end else if (mrsp_acc_s) begin
                data_r <= mrspdata_i;
                rerr_r <= mrsprerr_i;
            end
            if (flush_i & ((state_r == S_MREQ) | (state_r == S_MWAIT))) begin
                flushed_r <= 1'b1;
            end
        end
    end

    // Line valid bits; flush takes priority over a same-cycle install
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            valid_r <= '0;
        end else if (clk_en_i) begin
            if (flush_i) begin
                valid_r <= '0;
            end else if (install_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data storage, written on an installable refill
    always_ff @(posedge clk_i) begin
        if (install_s) begin
            tag_mem_r[fill_idx_s]  <= addr_r[WA_W-1:C_LINES_X];
            data_mem_r[fill_idx_s] <= mrspdata_i;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hit_r;
    logic [31:0] stat_miss_r;

    // Saturating hit/miss counters; clear wins over a same-cycle count
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            stat_hit_r  <= 32'd0;
            stat_miss_r <= 32'd0;
        end else if (clk_en_i) begin
            if (stat_clr_i) begin
                stat_hit_r  <= 32'd0;
                stat_miss_r <= 32'd0;
            end else begin
                if (req_acc_s & hit_s & (stat_hit_r != 32'hFFFF_FFFF)) begin
                    stat_hit_r <= stat_hit_r + 32'd1;
                end
                if (req_acc_s & ~hit_s & (stat_miss_r != 32'hFFFF_FFFF)) begin
                    stat_miss_r <= stat_miss_r + 32'd1;
                end
            end
        end
    end

    assign stat_hit_o  = stat_hit_r;
    assign stat_miss_o = stat_miss_r;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// -----------------------------------------------------------------------------
// tb_icache_dm -- directed bench for icache_dm. Stimulus pushes the expected
// fetch response (and expected refill address on a miss) into queues; a
// response monitor and a memory responder pop and compare independently.
// -----------------------------------------------------------------------------
module tb_icache_dm;

    logic        clk_i = 1'b0;
    logic        resetb_i;
    logic        clk_en_i;
    logic        ireqready_o;
    logic        ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspready_i;
    logic        irspvalid_o;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;
    logic        mreqready_i;
    logic        mreqvalid_o;
    logic [1:0]  mreqhpl_o;
    logic [31:0] mreqaddr_o;
    logic        mrspready_o;
    logic        mrspvalid_i;
    logic        mrsprerr_i;
    logic [31:0] mrspdata_i;
    logic        flush_i;
`ifdef ICACHE_STATS_EN
    logic        stat_clr_i;
    logic [31:0] stat_hit_o;
    logic [31:0] stat_miss_o;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    int          mreq_cnt    = 0;
    int          n_hit       = 0;
    int          n_miss      = 0;
    logic [32:0] exp_rsp_q[$];
    logic [31:0] exp_mreq_q[$];
    logic [31:0] mem_data;
    logic        mem_err;
    int          mem_lat     = 3;
    logic [32:0] mon_e;

    icache_dm dut (
        .clk_i       (clk_i),
        .resetb_i    (resetb_i),
        .clk_en_i    (clk_en_i),
        .ireqready_o (ireqready_o),
        .ireqvalid_i (ireqvalid_i),
        .ireqhpl_i   (ireqhpl_i),
        .ireqaddr_i  (ireqaddr_i),
        .irspready_i (irspready_i),
        .irspvalid_o (irspvalid_o),
        .irsprerr_o  (irsprerr_o),
        .irspdata_o  (irspdata_o),
        .mreqready_i (mreqready_i),
        .mreqvalid_o (mreqvalid_o),
        .mreqhpl_o   (mreqhpl_o),
        .mreqaddr_o  (mreqaddr_o),
        .mrspready_o (mrspready_o),
        .mrspvalid_i (mrspvalid_i),
        .mrsprerr_i  (mrsprerr_i),
        .mrspdata_i  (mrspdata_i),
        .flush_i     (flush_i)
`ifdef ICACHE_STATS_EN
        ,
        .stat_clr_i  (stat_clr_i),
        .stat_hit_o  (stat_hit_o),
        .stat_miss_o (stat_miss_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every accepted fetch response is checked in order
    always @(negedge clk_i) begin
        if (resetb_i && clk_en_i && irspvalid_o && irspready_i) begin
            if (exp_rsp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got data 0x%h, expected no response", irspdata_o);
            end else begin
                mon_e = exp_rsp_q.pop_front();
                chk("irsp_err_data", {31'd0, irsprerr_o, irspdata_o}, {31'd0, mon_e});
            end
        end
    end

    // Memory responder: checks each refill request, answers after mem_lat cycles
    initial begin
        mreqready_i = 1'b1;
        mrspvalid_i = 1'b0;
        mrsprerr_i  = 1'b0;
        mrspdata_i  = 32'd0;
        forever begin
            @(negedge clk_i);
            if (resetb_i && clk_en_i && mreqvalid_o && mreqready_i) begin
                mreq_cnt++;
                if (exp_mreq_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_mreq: got addr 0x%h, expected no request", mreqaddr_o);
                end else begin
                    chk("mreqaddr", {32'd0, mreqaddr_o}, {32'd0, exp_mreq_q.pop_front()});
                end
                chk("mreqhpl", {62'd0, mreqhpl_o}, 64'd3);
                @(posedge clk_i);
                repeat (mem_lat - 1) @(posedge clk_i);
                #1;
                mrspvalid_i = 1'b1;
                mrsprerr_i  = mem_err;
                mrspdata_i  = mem_data;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk_i);
                    if (clk_en_i && mrspready_o) break;
                end
                @(posedge clk_i);
                #1;
                mrspvalid_i = 1'b0;
                mrsprerr_i  = 1'b0;
                mrspdata_i  = 32'd0;
            end
        end
    end

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk_i);
            if (exp_rsp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("drain_timeout", 64'd0, 64'd1);
            exp_rsp_q.delete();
        end
        #1;
    endtask

    // One fetch: hold>0 stalls irspready (or clk_en when gate) for hold cycles
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                         input logic miss, input int hold, input logic gate, input logic do_flush);
        int c0;
        bit ok = 1'b0;
        c0 = mreq_cnt;
        if (miss) begin
            mem_data = data;
            mem_err  = err;
            exp_mreq_q.push_back({addr[31:2], 2'b00});
            n_miss++;
        end else begin
            n_hit++;
        end
        exp_rsp_q.push_back({err, data});
        ireqvalid_i = 1'b1;
        ireqaddr_i  = addr;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (ireqready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ireq_accept_timeout", 64'd0, 64'd1);
        @(posedge clk_i);
        #1;
        ireqvalid_i = 1'b0;
        if (hold > 0) begin
            if (gate) clk_en_i = 1'b0;
            else irspready_i = 1'b0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk_i);
                if (miss) begin
                    chk("stall_mreqvalid", {63'd0, mreqvalid_o}, 64'd1);
                    chk("stall_mreqaddr", {32'd0, mreqaddr_o}, {32'd0, addr[31:2], 2'b00});
                end else begin
                    chk("stall_irspvalid", {63'd0, irspvalid_o}, 64'd1);
                    chk("stall_irspdata", {31'd0, irsprerr_o, irspdata_o}, {31'd0, err, data});
                end
                if (gate) chk("gate_ireqready", {63'd0, ireqready_o}, 64'd0);
            end
            @(posedge clk_i);
            #1;
            clk_en_i    = 1'b1;
            irspready_i = 1'b1;
        end else begin
            @(negedge clk_i);
            chk("rsp_latency", {63'd0, irspvalid_o}, {63'd0, !miss});
        end
        if (do_flush) begin
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk_i);
                if (mrspready_o) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("mwait_timeout", 64'd0, 64'd1);
            @(posedge clk_i);
            #1 flush_i = 1'b1;
            @(posedge clk_i);
            #1 flush_i = 1'b0;
        end
        drain();
        chk("mreq_count", 64'(mreq_cnt - c0), {63'd0, miss});
    endtask

    initial begin
        int c0;
        resetb_i    = 1'b0;
        clk_en_i    = 1'b0;
        ireqvalid_i = 1'b0;
        ireqaddr_i  = 32'd0;
        ireqhpl_i   = 2'b11;
        irspready_i = 1'b1;
        flush_i     = 1'b0;
        mem_data    = 32'd0;
        mem_err     = 1'b0;
`ifdef ICACHE_STATS_EN
        stat_clr_i  = 1'b0;
`endif
        // Reset values
        #12;
        chk("rst_ireqready_clken0", {63'd0, ireqready_o}, 64'd0);
        clk_en_i = 1'b1;
        #1;
        chk("rst_ireqready", {63'd0, ireqready_o}, 64'd1);
        chk("rst_irspvalid", {63'd0, irspvalid_o}, 64'd0);
        chk("rst_mreqvalid", {63'd0, mreqvalid_o}, 64'd0);
        chk("rst_mrspready", {63'd0, mrspready_o}, 64'd0);
        chk("rst_irsprerr", {63'd0, irsprerr_o}, 64'd0);
        chk("rst_irspdata", {32'd0, irspdata_o}, 64'd0);
        chk("rst_mreqaddr", {32'd0, mreqaddr_o}, 64'd0);
        chk("rst_mreqhpl", {62'd0, mreqhpl_o}, 64'd0);
        #5 resetb_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Cold miss, then hit
        fetch(32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        fetch(32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Conflict on index 0
        fetch(32'h140, 32'h5140_5140, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        fetch(32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("conflict_total_mreq", 64'(mreq_cnt), 64'd3);

        // Prefill then back-to-back hits
        fetch(32'h0, 32'hA000_0000, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        fetch(32'h4, 32'hA000_0004, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        fetch(32'h8, 32'hA000_0008, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        c0 = mreq_cnt;
        exp_rsp_q.push_back({1'b0, 32'hA000_0000});
        exp_rsp_q.push_back({1'b0, 32'hA000_0004});
        exp_rsp_q.push_back({1'b0, 32'hA000_0008});
        n_hit += 3;
        ireqvalid_i = 1'b1;
        ireqaddr_i  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("b2b_ireqready", {63'd0, ireqready_o}, 64'd1);
            if (i > 0) chk("b2b_irspvalid", {63'd0, irspvalid_o}, 64'd1);
            @(posedge clk_i);
            #1;
            if (i < 2) ireqaddr_i = 32'(4 * (i + 1));
            else ireqvalid_i = 1'b0;
        end
        @(negedge clk_i);
        chk("b2b_irspvalid", {63'd0, irspvalid_o}, 64'd1);
        drain();
        chk("b2b_mreq_count", 64'(mreq_cnt - c0), 64'd0);

        // Error refill is forwarded but not cached
        fetch(32'h200, 32'hBAD0_0200, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        fetch(32'h200, 32'h0000_C200, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        fetch(32'h200, 32'h0000_C200, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Flush during MWAIT: data forwarded, nothing stays valid
        fetch(32'h300, 32'h3333_0300, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        fetch(32'h300, 32'h3333_0300, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        fetch(32'h4,   32'hA000_0004, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        fetch(32'h8,   32'hA000_0008, 1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Backpressure on a hit, clk_en low on a hit and on a miss
        fetch(32'h4,  32'hA000_0004, 1'b0, 1'b0, 5, 1'b0, 1'b0);
        fetch(32'h8,  32'hA000_0008, 1'b0, 1'b0, 4, 1'b1, 1'b0);
        fetch(32'h40, 32'h4040_4040, 1'b0, 1'b1, 4, 1'b1, 1'b0);

`ifdef ICACHE_STATS_EN
        chk("stat_hit", {32'd0, stat_hit_o}, 64'(n_hit));
        chk("stat_miss", {32'd0, stat_miss_o}, 64'(n_miss));
        stat_clr_i = 1'b1;
        @(posedge clk_i);
        #1 stat_clr_i = 1'b0;
        chk("stat_hit_clr", {32'd0, stat_hit_o}, 64'd0);
        chk("stat_miss_clr", {32'd0, stat_miss_o}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
